// File: rtl/ysyx_23060042_pkg.sv
// Shared types for the NPC execution sequencer: FSM state encoding and memory-enable constants.
package ysyx_23060042_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      IWAIT  = 3'd1,
      DECODE = 3'd2,
      MREQ   = 3'd3,
      MWAIT  = 3'd4,
      WB     = 3'd5,
      HALT   = 3'd6,
      ERR    = 3'd7
   } ctrl_state_e;

   localparam logic [1:0] MEM_NONE = 2'b00;

endpackage

// File: rtl/ysyx_23060042_wait_timer.sv
// Bus-wait watchdog: counts enabled cycles since the last clear and flags the last allowed cycle.
module ysyx_23060042_wait_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] Limit   = CntW'(TIMEOUT_CYCLES);
   localparam logic [CntW-1:0] LimitM1 = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != Limit)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Asserted during the TIMEOUT_CYCLES-th waiting cycle so ERR is entered on the following one.
   assign expire_o = en_i && (cnt_q >= LimitM1);

endmodule

// File: rtl/ysyx_23060042_exec_ctrl.sv
// Multi-cycle fetch/decode/memory/writeback sequencer for the NPC core.
// Define EXEC_CTRL_PERF_EN to add the perf_cycle / perf_instret counters.
module ysyx_23060042_exec_ctrl
   import ysyx_23060042_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned PERF_W         = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       ifu_req_valid,
   input  logic       ifu_req_ready,
   input  logic       ifu_resp_valid,
   output logic       inst_we,
   input  logic       dec_regen,
   input  logic       dec_pcjen,
   input  logic [1:0] dec_mwen,
   input  logic [1:0] dec_mren,
   input  logic       dec_brken,
   output logic       lsu_req_valid,
   output logic       lsu_req_we,
   input  logic       lsu_req_ready,
   input  logic       lsu_resp_valid,
   output logic       rf_we,
   output logic       pc_we,
   output logic       retire,
   output logic       halted,
   output logic       err
`ifdef EXEC_CTRL_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_cycle,
   output logic [PERF_W-1:0] perf_instret
`endif
);

   ctrl_state_e state_q, state_d;
   logic        tmo_expire;
   logic        tmo_en;

   // PC source selection lives in the datapath; the sequencer only pulses pc_we.
   logic unused_pcjen;
   assign unused_pcjen = dec_pcjen;

   assign tmo_en = (state_q == FETCH) || (state_q == IWAIT) ||
                   (state_q == MREQ)  || (state_q == MWAIT);

   ysyx_23060042_wait_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (state_d != state_q),
      .en_i    (tmo_en),
      .expire_o(tmo_expire)
   );

   // A handshake or response on the expiring cycle takes priority over the timeout.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FETCH: begin
            if (ifu_req_ready)   state_d = IWAIT;
            else if (tmo_expire) state_d = ERR;
         end
         IWAIT: begin
            if (ifu_resp_valid)  state_d = DECODE;
            else if (tmo_expire) state_d = ERR;
         end
         DECODE: begin
            if (dec_brken)                                         state_d = HALT;
            else if ((dec_mwen != MEM_NONE) && (dec_mren != MEM_NONE)) state_d = ERR;
            else if ((dec_mwen | dec_mren) != MEM_NONE)            state_d = MREQ;
            else                                                   state_d = WB;
         end
         MREQ: begin
            if (lsu_req_ready)   state_d = MWAIT;
            else if (tmo_expire) state_d = ERR;
         end
         MWAIT: begin
            if (lsu_resp_valid)  state_d = WB;
            else if (tmo_expire) state_d = ERR;
         end
         WB:      state_d = FETCH;
         HALT:    state_d = HALT;
         ERR:     state_d = ERR;
         default: state_d = ERR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Outputs are forced low while rst_n is held, even though the reset state is FETCH.
   always_comb begin
      ifu_req_valid = 1'b0;
      inst_we       = 1'b0;
      lsu_req_valid = 1'b0;
      lsu_req_we    = 1'b0;
      rf_we         = 1'b0;
      pc_we         = 1'b0;
      retire        = 1'b0;
      halted        = 1'b0;
      err           = 1'b0;
      if (rst_n) begin
         unique case (state_q)
            FETCH: ifu_req_valid = 1'b1;
            IWAIT: inst_we       = ifu_resp_valid;
            MREQ: begin
               lsu_req_valid = 1'b1;
               lsu_req_we    = |dec_mwen;
            end
            WB: begin
               rf_we  = dec_regen & ~(|dec_mwen);
               pc_we  = 1'b1;
               retire = 1'b1;
            end
            HALT:    halted = 1'b1;
            ERR:     err    = 1'b1;
            default: ;
         endcase
      end
   end

`ifdef EXEC_CTRL_PERF_EN
   logic [PERF_W-1:0] cycle_q, instret_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         if ((state_q != HALT) && (state_q != ERR)) cycle_q <= cycle_q + 1'b1;
         if (retire) instret_q <= instret_q + 1'b1;
      end
   end

   assign perf_cycle   = cycle_q;
   assign perf_instret = instret_q;
`else
   logic [PERF_W-1:0] unused_perf_w;
   assign unused_perf_w = '0;
`endif

endmodule
